// File: rtl/operand_pair_drain_fifo_if.sv
// Handshake bundle between the operand delay line, the pair FIFO and its consumer.
// The FIFO takes the slave side; the producer/consumer bench side takes the master side.
interface operand_pair_drain_fifo_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_1;
    logic [WIDTH-1:0] out_2;
    logic             out_ready;

    modport slave (
        input  in_valid, in_1, in_2, out_ready,
        output in_ready, out_valid, out_1, out_2
    );

    modport master (
        output in_valid, in_1, in_2, out_ready,
        input  in_ready, out_valid, out_1, out_2
    );
endinterface

// File: rtl/operand_pair_drain_fifo.sv
// Elastic receive buffer for operand pairs leaving a non-stallable 2-stage delay line.
// Credit (in_ready) drops early so the two in-flight pairs always find room.
module operand_pair_drain_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_pair_drain_fifo_if.slave bus,
    output logic [CNT_W-1:0]     count,
    output logic                 overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;

    logic               w_out_valid;
    logic               w_pop;
    logic               w_push;
    logic [2*WIDTH-1:0] w_head;

    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready;
    assign w_push      = bus.in_valid & ((r_count < CNT_W'(DEPTH)) | w_pop);
    assign w_head      = r_mem[r_rd_ptr];

    assign bus.out_valid = w_out_valid;
    assign bus.out_1     = w_out_valid ? w_head[WIDTH-1:0] : '0;
    assign bus.out_2     = w_out_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
    assign bus.in_ready  = (r_count <= CNT_W'(DEPTH - 3));
    assign count         = r_count;
    assign overflow      = r_overflow;

    // Storage is deliberately left out of reset; only pointers/count matter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_2, bus.in_1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.in_valid & ~w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule
